gmux_qen_seq: RTL and testbench

Synchronous sequencer that drives the per-quadrant enable bundle (`x_SEN`, `x_DEN`, `x_DYNEN`, `x_VLP` for x = BL, BR, TL, TR) and the source select `SSEL` of the global clock mux directly downstream.
- Source changes and quadrant mask updates pass through a break-before-make sequence: staggered disable, guard, apply, guard, staggered enable. Quadrant clocks therefore never see a glitch or a simultaneous load step.
- It also owns low-power (VLP) entry and exit for the quadrants.

---
 rtl/gmux_qen_seq_if.sv | 35 +++
 rtl/gmux_qen_seq.sv | 206 ++++++++++++++++++++
 tb/tb_gmux_qen_seq.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gmux_qen_seq_if.sv
// Request/status bundle between a clock-mux controller and the quadrant
// enable sequencer. Quadrant vectors use bit order {TR,TL,BR,BL}.
interface gmux_qen_seq_if;
  logic [3:0] QMASK;
  logic       SSEL_REQ;
  logic       UPD;
  logic       LP_REQ;
  logic       BUSY;
  logic       DONE;
  logic       SSEL;
  logic       BL_SEN,   BR_SEN,   TL_SEN,   TR_SEN;
  logic       BL_DEN,   BR_DEN,   TL_DEN,   TR_DEN;
  logic       BL_DYNEN, BR_DYNEN, TL_DYNEN, TR_DYNEN;
  logic       BL_VLP,   BR_VLP,   TL_VLP,   TR_VLP;

  // Requester side: issues mask/select updates and low-power requests.
  modport master (
    output QMASK, SSEL_REQ, UPD, LP_REQ,
    input  BUSY, DONE, SSEL,
    input  BL_SEN, BR_SEN, TL_SEN, TR_SEN,
    input  BL_DEN, BR_DEN, TL_DEN, TR_DEN,
    input  BL_DYNEN, BR_DYNEN, TL_DYNEN, TR_DYNEN,
    input  BL_VLP, BR_VLP, TL_VLP, TR_VLP
  );

  // Sequencer side: drives the enable bundle and the mux select.
  modport slave (
    input  QMASK, SSEL_REQ, UPD, LP_REQ,
    output BUSY, DONE, SSEL,
    output BL_SEN, BR_SEN, TL_SEN, TR_SEN,
    output BL_DEN, BR_DEN, TL_DEN, TR_DEN,
    output BL_DYNEN, BR_DYNEN, TL_DYNEN, TR_DYNEN,
    output BL_VLP, BR_VLP, TL_VLP, TR_VLP
  );
endinterface

// File: rtl/gmux_qen_seq.sv
// Break-before-make sequencer for the global clock mux quadrant enables.
// Every mask/source change walks: staggered DYNEN clear, guard, apply
// SSEL/SEN/DEN, guard, staggered DYNEN set. Also runs VLP sleep/wake.
module gmux_qen_seq #(
  parameter int unsigned GUARD_CYC = 4,
  parameter int unsigned STAGGER   = 1
) (
  input  logic          CLK,
  input  logic          RST,
  gmux_qen_seq_if.slave bus
);

  typedef enum logic [3:0] {
    OFF, DOWN, GUARD_A, APPLY, GUARD_B, UP, RUN, SLEEP, WAKE
  } state_t;

  // GUARD_A hands over to a one-cycle APPLY state, so it is loaded two short
  // of the guard length; a one-cycle guard skips GUARD_A entirely.
  localparam logic [3:0] GC_LOAD   = 4'(GUARD_CYC - 1);
  localparam logic [3:0] GC_A_LOAD = (GUARD_CYC > 1) ? 4'(GUARD_CYC - 2) : 4'd0;
  localparam logic [2:0] SC_LOAD   = 3'(STAGGER - 1);

  function automatic logic [3:0] lowest_one(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  state_t     state_q;
  logic [3:0] m_q, sen_q, den_q, dyn_q, vlp_q;
  logic       s_q, ssel_q, lp_q, busy_q, done_q;
  logic [3:0] gc_q;
  logic [2:0] sc_q;

  logic [3:0] dyn_low, dyn_left, up_pend, up_low, up_left;

  // Next quadrant to switch off/on, walking BL, BR, TL, TR.
  always_comb begin
    dyn_low  = lowest_one(dyn_q);
    dyn_left = dyn_q & ~dyn_low;
    up_pend  = m_q & ~dyn_q;
    up_low   = lowest_one(up_pend);
    up_left  = up_pend & ~up_low;
  end

  // Sequencer FSM; all outputs are registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= OFF;
      m_q     <= '0;
      sen_q   <= '0;
      den_q   <= '0;
      dyn_q   <= '0;
      vlp_q   <= '0;
      s_q     <= 1'b0;
      ssel_q  <= 1'b0;
      lp_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gc_q    <= '0;
      sc_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        OFF, RUN: begin
          // Low-power request outranks a coincident update.
          if (bus.LP_REQ || bus.UPD) begin
            busy_q <= 1'b1;
            lp_q   <= bus.LP_REQ;
            if (!bus.LP_REQ) begin
              m_q <= bus.QMASK;
              s_q <= bus.SSEL_REQ;
            end
            if (dyn_q == 4'd0) begin
              state_q <= (GUARD_CYC == 1) ? APPLY : GUARD_A;
              gc_q    <= GC_A_LOAD;
            end else begin
              state_q <= DOWN;
              sc_q    <= SC_LOAD;
            end
          end
        end

        DOWN: begin
          if (sc_q == 3'd0) begin
            dyn_q <= dyn_left;
            sc_q  <= SC_LOAD;
            if (dyn_left == 4'd0) begin
              state_q <= (GUARD_CYC == 1) ? APPLY : GUARD_A;
              gc_q    <= GC_A_LOAD;
            end
          end else begin
            sc_q <= sc_q - 3'd1;
          end
        end

        GUARD_A: begin
          if (gc_q == 4'd0) state_q <= APPLY;
          else              gc_q    <= gc_q - 4'd1;
        end

        APPLY: begin
          if (lp_q) begin
            // Sleep: drop drivers, hold powered quadrants in VLP, keep SEN.
            den_q   <= '0;
            vlp_q   <= sen_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= SLEEP;
          end else begin
            ssel_q <= s_q;
            sen_q  <= m_q;
            den_q  <= m_q;
            if (m_q == 4'd0) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= OFF;
            end else begin
              state_q <= GUARD_B;
              gc_q    <= GC_LOAD;
            end
          end
        end

        GUARD_B: begin
          if (gc_q == 4'd0) begin
            dyn_q <= dyn_q | up_low;
            if (up_left == 4'd0) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= RUN;
            end else begin
              state_q <= UP;
              sc_q    <= SC_LOAD;
            end
          end else begin
            gc_q <= gc_q - 4'd1;
          end
        end

        UP: begin
          if (sc_q == 3'd0) begin
            dyn_q <= dyn_q | up_low;
            sc_q  <= SC_LOAD;
            if (up_left == 4'd0) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= RUN;
            end
          end else begin
            sc_q <= sc_q - 3'd1;
          end
        end

        SLEEP: begin
          if (!bus.LP_REQ) begin
            vlp_q   <= '0;
            busy_q  <= 1'b1;
            lp_q    <= 1'b0;
            gc_q    <= GC_LOAD;
            state_q <= WAKE;
          end
        end

        WAKE: begin
          // Re-enable drivers after the guard, then reuse GUARD_B/UP to ramp.
          if (gc_q == 4'd0) begin
            den_q <= sen_q;
            m_q   <= sen_q;
            if (sen_q == 4'd0) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= OFF;
            end else begin
              state_q <= GUARD_B;
              gc_q    <= GC_LOAD;
            end
          end else begin
            gc_q <= gc_q - 4'd1;
          end
        end

        default: state_q <= OFF;
      endcase
    end
  end

  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.SSEL     = ssel_q;
  assign bus.BL_SEN   = sen_q[0];
  assign bus.BR_SEN   = sen_q[1];
  assign bus.TL_SEN   = sen_q[2];
  assign bus.TR_SEN   = sen_q[3];
  assign bus.BL_DEN   = den_q[0];
  assign bus.BR_DEN   = den_q[1];
  assign bus.TL_DEN   = den_q[2];
  assign bus.TR_DEN   = den_q[3];
  assign bus.BL_DYNEN = dyn_q[0];
  assign bus.BR_DYNEN = dyn_q[1];
  assign bus.TL_DYNEN = dyn_q[2];
  assign bus.TR_DYNEN = dyn_q[3];
  assign bus.BL_VLP   = vlp_q[0];
  assign bus.BR_VLP   = vlp_q[1];
  assign bus.TL_VLP   = vlp_q[2];
  assign bus.TR_VLP   = vlp_q[3];

endmodule

// File: tb/tb_gmux_qen_seq.sv
// Directed scoreboard bench for gmux_qen_seq (GUARD_CYC=4, STAGGER=1).
// Observed vector: {BUSY, DONE, SSEL, SEN[3:0], DEN[3:0], DYNEN[3:0], VLP[3:0]},
// quadrant nibbles ordered {TR,TL,BR,BL}.
module tb_gmux_qen_seq;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  int   exp_done = 0;
  logic end_req = 1'b0;
  logic end_ack = 1'b0;

  typedef struct {
    int          cyc;
    logic [18:0] val;
    string       nm;
  } exp_t;
  exp_t sbq[$];

  gmux_qen_seq_if bus();

  gmux_qen_seq #(.GUARD_CYC(4), .STAGGER(1)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [18:0] V(input logic b, input logic d, input logic s,
                                    input logic [3:0] sen, input logic [3:0] den,
                                    input logic [3:0] dyn, input logic [3:0] vlp);
    return {b, d, s, sen, den, dyn, vlp};
  endfunction

  function automatic logic [18:0] observe();
    return {bus.BUSY, bus.DONE, bus.SSEL,
            bus.TR_SEN, bus.TL_SEN, bus.BR_SEN, bus.BL_SEN,
            bus.TR_DEN, bus.TL_DEN, bus.BR_DEN, bus.BL_DEN,
            bus.TR_DYNEN, bus.TL_DYNEN, bus.BR_DYNEN, bus.BL_DYNEN,
            bus.TR_VLP, bus.TL_VLP, bus.BR_VLP, bus.BL_VLP};
  endfunction

  task automatic chk(input int c, input string nm, input logic [18:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    e.nm  = nm;
    sbq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_upd(input logic [3:0] m, input logic s);
    bus.QMASK    = m;
    bus.SSEL_REQ = s;
    bus.UPD      = 1'b1;
    @(negedge clk);
    bus.UPD      = 1'b0;
  endtask

  // Power-up from OFF: mask 0101, SSEL_REQ=1.
  task automatic powerup(input string tag);
    int e0;
    e0 = cyc + 1;
    chk(e0,      {tag, "_e0"},  V(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    chk(e0 + 3,  {tag, "_e3"},  V(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    chk(e0 + 4,  {tag, "_e4"},  V(1, 0, 1, 4'b0101, 4'b0101, 4'b0000, 4'b0000));
    chk(e0 + 7,  {tag, "_e7"},  V(1, 0, 1, 4'b0101, 4'b0101, 4'b0000, 4'b0000));
    chk(e0 + 8,  {tag, "_e8"},  V(1, 0, 1, 4'b0101, 4'b0101, 4'b0001, 4'b0000));
    chk(e0 + 9,  {tag, "_e9"},  V(0, 1, 1, 4'b0101, 4'b0101, 4'b0101, 4'b0000));
    chk(e0 + 10, {tag, "_e10"}, V(0, 0, 1, 4'b0101, 4'b0101, 4'b0101, 4'b0000));
    exp_done++;
    drive_upd(4'b0101, 1'b1);
    tick(11);
  endtask

  // Scoreboard monitor plus running invariant checks.
  logic        prev_ssel;
  logic [3:0]  prev_dyn;
  always @(negedge clk) begin
    logic [18:0] obs;
    logic [3:0]  sen, den, dyn, vlp;
    exp_t        e;
    obs = observe();
    {sen, den, dyn, vlp} = obs[15:0];
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: check for edge %0d not reached in time (now %0d)", e.nm, e.cyc, cyc);
      end else if (obs !== e.val) begin
        bad++;
        $display("FAIL %s at edge %0d: actual=%b required=%b", e.nm, cyc, obs, e.val);
      end
    end
    if (cyc >= 2) begin
      if (bus.DONE === 1'b1) done_seen++;
      total++;
      if ((dyn & ~(den & sen)) != 4'd0) begin
        bad++;
        $display("FAIL inv_dyn_en at edge %0d: dyn=%b den=%b sen=%b required dyn within den&sen", cyc, dyn, den, sen);
      end
      total++;
      if ((vlp & den) != 4'd0) begin
        bad++;
        $display("FAIL inv_vlp_den at edge %0d: vlp=%b den=%b required no overlap", cyc, vlp, den);
      end
      if (prev_ssel !== bus.SSEL) begin
        total++;
        if ((prev_dyn | dyn) != 4'd0) begin
          bad++;
          $display("FAIL inv_ssel at edge %0d: dyn before=%b after=%b required 0000 around SSEL change", cyc, prev_dyn, dyn);
        end
      end
    end
    prev_ssel = bus.SSEL;
    prev_dyn  = dyn;
    if (end_req && !end_ack) begin
      total++;
      if (sbq.size() != 0) begin
        bad++;
        $display("FAIL scoreboard_drain: actual=%0d pending required=0", sbq.size());
      end
      total++;
      if (done_seen != exp_done) begin
        bad++;
        $display("FAIL done_count: actual=%0d required=%0d", done_seen, exp_done);
      end
      end_ack = 1'b1;
    end
  end

  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within 3000 cycles");
    $fatal(1, "timeout");
  end

  initial begin
    int e0, w0;
    rst          = 1'b1;
    bus.UPD      = 1'b0;
    bus.LP_REQ   = 1'b0;
    bus.QMASK    = 4'b0000;
    bus.SSEL_REQ = 1'b0;
    chk(1, "reset_e1", V(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    chk(2, "reset_e2", V(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tick(2);
    rst = 1'b0;
    tick(1);

    powerup("pwr1");

    // RUN 0101 -> 1111 keeping SSEL=1.
    e0 = cyc + 1;
    chk(e0 + 1,  "grow_e1",   V(1, 0, 1, 4'b0101, 4'b0101, 4'b0100, 4'b0000));
    chk(e0 + 2,  "grow_e2",   V(1, 0, 1, 4'b0101, 4'b0101, 4'b0000, 4'b0000));
    chk(e0 + 6,  "grow_e6",   V(1, 0, 1, 4'b1111, 4'b1111, 4'b0000, 4'b0000));
    chk(e0 + 10, "grow_e10",  V(1, 0, 1, 4'b1111, 4'b1111, 4'b0001, 4'b0000));
    chk(e0 + 13, "grow_e13",  V(0, 1, 1, 4'b1111, 4'b1111, 4'b1111, 4'b0000));
    exp_done++;
    drive_upd(4'b1111, 1'b1);
    tick(14);

    // Source switch to GCLKIN with mask 1111.
    e0 = cyc + 1;
    chk(e0 + 1,  "sw_e1",  V(1, 0, 1, 4'b1111, 4'b1111, 4'b1110, 4'b0000));
    chk(e0 + 4,  "sw_e4",  V(1, 0, 1, 4'b1111, 4'b1111, 4'b0000, 4'b0000));
    chk(e0 + 7,  "sw_e7",  V(1, 0, 1, 4'b1111, 4'b1111, 4'b0000, 4'b0000));
    chk(e0 + 8,  "sw_e8",  V(1, 0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0000));
    chk(e0 + 12, "sw_e12", V(1, 0, 0, 4'b1111, 4'b1111, 4'b0001, 4'b0000));
    chk(e0 + 15, "sw_e15", V(0, 1, 0, 4'b1111, 4'b1111, 4'b1111, 4'b0000));
    chk(e0 + 16, "sw_e16", V(0, 0, 0, 4'b1111, 4'b1111, 4'b1111, 4'b0000));
    exp_done++;
    drive_upd(4'b1111, 1'b0);
    tick(17);

    // Shrink to 0011; a second UPD arrives while busy and must be dropped.
    e0 = cyc + 1;
    chk(e0 + 4,  "drop_e4",  V(1, 0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0000));
    chk(e0 + 8,  "drop_e8",  V(1, 0, 0, 4'b0011, 4'b0011, 4'b0000, 4'b0000));
    chk(e0 + 12, "drop_e12", V(1, 0, 0, 4'b0011, 4'b0011, 4'b0001, 4'b0000));
    chk(e0 + 13, "drop_e13", V(0, 1, 0, 4'b0011, 4'b0011, 4'b0011, 4'b0000));
    chk(e0 + 18, "drop_e18", V(0, 0, 0, 4'b0011, 4'b0011, 4'b0011, 4'b0000));
    exp_done++;
    drive_upd(4'b0011, 1'b0);
    tick(2);
    drive_upd(4'b1000, 1'b1);
    tick(16);

    // Sleep then wake with mask 0011.
    e0 = cyc + 1;
    chk(e0 + 1, "slp_e1", V(1, 0, 0, 4'b0011, 4'b0011, 4'b0010, 4'b0000));
    chk(e0 + 2, "slp_e2", V(1, 0, 0, 4'b0011, 4'b0011, 4'b0000, 4'b0000));
    chk(e0 + 5, "slp_e5", V(1, 0, 0, 4'b0011, 4'b0011, 4'b0000, 4'b0000));
    chk(e0 + 6, "slp_e6", V(0, 1, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0011));
    chk(e0 + 9, "slp_e9", V(0, 0, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0011));
    exp_done++;
    bus.LP_REQ = 1'b1;
    tick(10);
    w0 = cyc + 1;
    chk(w0,      "wake_w0",  V(1, 0, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0000));
    chk(w0 + 3,  "wake_w3",  V(1, 0, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0000));
    chk(w0 + 4,  "wake_w4",  V(1, 0, 0, 4'b0011, 4'b0011, 4'b0000, 4'b0000));
    chk(w0 + 8,  "wake_w8",  V(1, 0, 0, 4'b0011, 4'b0011, 4'b0001, 4'b0000));
    chk(w0 + 9,  "wake_w9",  V(0, 1, 0, 4'b0011, 4'b0011, 4'b0011, 4'b0000));
    chk(w0 + 10, "wake_w10", V(0, 0, 0, 4'b0011, 4'b0011, 4'b0011, 4'b0000));
    exp_done++;
    bus.LP_REQ = 1'b0;
    tick(11);

    // UPD and LP_REQ together: LP wins; LP_REQ drops while busy (deferred wake).
    e0 = cyc + 1;
    chk(e0 + 1,  "sim_e1",  V(1, 0, 0, 4'b0011, 4'b0011, 4'b0010, 4'b0000));
    chk(e0 + 6,  "sim_e6",  V(0, 1, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0011));
    chk(e0 + 7,  "sim_e7",  V(1, 0, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0000));
    chk(e0 + 11, "sim_e11", V(1, 0, 0, 4'b0011, 4'b0011, 4'b0000, 4'b0000));
    chk(e0 + 15, "sim_e15", V(1, 0, 0, 4'b0011, 4'b0011, 4'b0001, 4'b0000));
    chk(e0 + 16, "sim_e16", V(0, 1, 0, 4'b0011, 4'b0011, 4'b0011, 4'b0000));
    chk(e0 + 17, "sim_e17", V(0, 0, 0, 4'b0011, 4'b0011, 4'b0011, 4'b0000));
    exp_done += 2;
    bus.LP_REQ = 1'b1;
    drive_upd(4'b1100, 1'b1);
    tick(3);
    bus.LP_REQ = 1'b0;
    tick(15);

    // Reset during GUARD_B of a 0011 -> 0110 update, then power up again.
    e0 = cyc + 1;
    chk(e0 + 1, "rstm_e1", V(1, 0, 0, 4'b0011, 4'b0011, 4'b0010, 4'b0000));
    chk(e0 + 6, "rstm_e6", V(1, 0, 1, 4'b0110, 4'b0110, 4'b0000, 4'b0000));
    chk(e0 + 8, "rstm_e8", V(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    chk(e0 + 9, "rstm_e9", V(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    drive_upd(4'b0110, 1'b1);
    tick(7);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    powerup("pwr2");

    // RUN 0101 -> 1000.
    e0 = cyc + 1;
    chk(e0 + 1,  "tr_e1",  V(1, 0, 1, 4'b0101, 4'b0101, 4'b0100, 4'b0000));
    chk(e0 + 6,  "tr_e6",  V(1, 0, 1, 4'b1000, 4'b1000, 4'b0000, 4'b0000));
    chk(e0 + 10, "tr_e10", V(0, 1, 1, 4'b1000, 4'b1000, 4'b1000, 4'b0000));
    exp_done++;
    drive_upd(4'b1000, 1'b1);
    tick(11);

    // Disable all from RUN 1000.
    e0 = cyc + 1;
    chk(e0 + 1, "off_e1", V(1, 0, 1, 4'b1000, 4'b1000, 4'b0000, 4'b0000));
    chk(e0 + 4, "off_e4", V(1, 0, 1, 4'b1000, 4'b1000, 4'b0000, 4'b0000));
    chk(e0 + 5, "off_e5", V(0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    chk(e0 + 6, "off_e6", V(0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    exp_done++;
    drive_upd(4'b0000, 1'b1);
    tick(7);

    // LP entry from OFF and wake with nothing enabled.
    e0 = cyc + 1;
    chk(e0,     "lpoff_e0", V(1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    chk(e0 + 3, "lpoff_e3", V(1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    chk(e0 + 4, "lpoff_e4", V(0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    chk(e0 + 5, "lpoff_e5", V(0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    exp_done++;
    bus.LP_REQ = 1'b1;
    tick(6);
    w0 = cyc + 1;
    chk(w0,     "wkoff_w0", V(1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    chk(w0 + 3, "wkoff_w3", V(1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    chk(w0 + 4, "wkoff_w4", V(0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    chk(w0 + 5, "wkoff_w5", V(0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    exp_done++;
    bus.LP_REQ = 1'b0;
    tick(7);

    end_req = 1'b1;
    wait (end_ack);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
